// File: rtl/red_pitaya_trigger_gen.sv
// red_pitaya_trigger_gen: programmable trigger pulse-train generator
// with sys-bus register access and free-running-counter timestamps.
module red_pitaya_trigger_gen #(
    parameter int OUTBITS = 16,
    parameter int CTRBITS = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OUTBITS-1:0] trig_i,
    output logic [OUTBITS-1:0] trig_o,
    output logic               pulse_o,
    output logic               busy_o,
    input  logic [15:0]        addr,
    input  logic               wen,
    input  logic               ren,
    output logic               ack,
    output logic [31:0]        rdata,
    input  logic [31:0]        wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DELAY = 3'd2,
        S_HIGH  = 3'd3,
        S_LOW   = 3'd4
    } state_t;

    localparam logic [15:0] A_START  = 16'h100;
    localparam logic [15:0] A_CTRL   = 16'h104;
    localparam logic [15:0] A_MASK   = 16'h108;
    localparam logic [15:0] A_DELAY  = 16'h10C;
    localparam logic [15:0] A_WIDTH  = 16'h110;
    localparam logic [15:0] A_PERIOD = 16'h114;
    localparam logic [15:0] A_COUNT  = 16'h118;
    localparam logic [15:0] A_SMASK  = 16'h11C;
    localparam logic [15:0] A_ABORT  = 16'h120;
    localparam logic [15:0] A_CTR_LO = 16'h15C;
    localparam logic [15:0] A_CTR_HI = 16'h160;
    localparam logic [15:0] A_TS_LO  = 16'h164;
    localparam logic [15:0] A_TS_HI  = 16'h168;
    localparam logic [15:0] A_PULSES = 16'h16C;

    state_t state;
    state_t state_nxt;

    logic [1:0]         ctrl;
    logic [OUTBITS-1:0] out_mask;
    logic [OUTBITS-1:0] start_mask;
    logic [31:0]        delay_r;
    logic [31:0]        width_r;
    logic [31:0]        period_r;
    logic [31:0]        count_r;
    logic               start_strb;
    logic               abort_strb;

    logic [31:0]        sh_width;
    logic [31:0]        sh_period;
    logic [31:0]        sh_count;
    logic               sh_cont;
    logic [31:0]        cnt;
    logic [31:0]        pulses;
    logic [CTRBITS-1:0] ctr;
    logic [CTRBITS-1:0] tstamp;
    logic [OUTBITS-1:0] trig_prev;

    logic [31:0]        san_width;
    logic [31:0]        san_period;
    logic [31:0]        san_count;
    logic               ext_rise;
    logic               last_pulse;
    logic               launch;
    logic               enter_high;
    logic               enter_low;
    logic [OUTBITS-1:0] trig_nxt;
    logic               pulse_nxt;
    logic [31:0]        rd_mux;
    logic [63:0]        ctr64;
    logic [63:0]        ts64;

    assign ctr64 = 64'(ctr);
    assign ts64  = 64'(tstamp);

    // Run parameters are cleaned up once, when a run is launched.
    assign san_width  = (width_r == 32'd0) ? 32'd1 : width_r;
    assign san_period = (period_r <= san_width) ? san_width + 32'd1
                                                : period_r;
    assign san_count  = (count_r == 32'd0 && !ctrl[0]) ? 32'd1 : count_r;

    assign ext_rise   = |(trig_i & ~trig_prev & start_mask);
    assign last_pulse = !sh_cont && (pulses >= sh_count);
    assign launch     = (state == S_IDLE) && (state_nxt != S_IDLE);
    assign enter_high = (state_nxt == S_HIGH) && (state != S_HIGH);
    assign enter_low  = (state_nxt == S_LOW) && (state != S_LOW);
    assign busy_o     = (state != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_strb) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_strb) begin
                        state_nxt = ctrl[1] ? S_WAIT : S_DELAY;
                    end
                end
                S_WAIT: begin
                    if (ext_rise) begin
                        state_nxt = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (cnt == 32'd0) begin
                        state_nxt = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (cnt == 32'd0) begin
                        state_nxt = last_pulse ? S_IDLE : S_LOW;
                    end
                end
                S_LOW: begin
                    if (cnt == 32'd0) begin
                        state_nxt = S_HIGH;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they register in step.
    always_comb begin
        trig_nxt  = '0;
        pulse_nxt = 1'b0;
        if (state_nxt == S_HIGH) begin
            trig_nxt  = out_mask;
            pulse_nxt = (state != S_HIGH);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_o  <= '0;
            pulse_o <= 1'b0;
        end else begin
            trig_o  <= trig_nxt;
            pulse_o <= pulse_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_width  <= 32'd1;
            sh_period <= 32'd2;
            sh_count  <= 32'd1;
            sh_cont   <= 1'b0;
            cnt       <= '0;
            pulses    <= '0;
            ctr       <= '0;
            tstamp    <= '0;
            trig_prev <= '0;
        end else begin
            ctr       <= ctr + CTRBITS'(1);
            trig_prev <= trig_i;
            if (launch) begin
                sh_width  <= san_width;
                sh_period <= san_period;
                sh_count  <= san_count;
                sh_cont   <= ctrl[0];
                cnt       <= delay_r;
                pulses    <= '0;
            end else if (enter_high) begin
                cnt    <= sh_width - 32'd1;
                tstamp <= ctr;
                if (pulses != '1) begin
                    pulses <= pulses + 32'd1;
                end
            end else if (enter_low) begin
                cnt <= sh_period - sh_width - 32'd1;
            end else if (state != S_IDLE && state != S_WAIT
                         && cnt != 32'd0) begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_START:  rd_mux = {29'd0, state};
            A_CTRL:   rd_mux = {30'd0, ctrl};
            A_MASK:   rd_mux = 32'(out_mask);
            A_DELAY:  rd_mux = delay_r;
            A_WIDTH:  rd_mux = width_r;
            A_PERIOD: rd_mux = period_r;
            A_COUNT:  rd_mux = count_r;
            A_SMASK:  rd_mux = 32'(start_mask);
            A_CTR_LO: rd_mux = ctr64[31:0];
            A_CTR_HI: rd_mux = ctr64[63:32];
            A_TS_LO:  rd_mux = ts64[31:0];
            A_TS_HI:  rd_mux = ts64[63:32];
            A_PULSES: rd_mux = pulses;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack        <= 1'b0;
            rdata      <= '0;
            start_strb <= 1'b0;
            abort_strb <= 1'b0;
            ctrl       <= '0;
            out_mask   <= '0;
            start_mask <= '0;
            delay_r    <= '0;
            width_r    <= 32'd1;
            period_r   <= 32'd2;
            count_r    <= 32'd1;
        end else begin
            ack        <= wen | ren;
            rdata      <= ren ? rd_mux : 32'd0;
            start_strb <= wen && (addr == A_START);
            abort_strb <= wen && (addr == A_ABORT);
            if (wen) begin
                case (addr)
                    A_CTRL:   ctrl       <= wdata[1:0];
                    A_MASK:   out_mask   <= wdata[OUTBITS-1:0];
                    A_DELAY:  delay_r    <= wdata;
                    A_WIDTH:  width_r    <= wdata;
                    A_PERIOD: period_r   <= wdata;
                    A_COUNT:  count_r    <= wdata;
                    A_SMASK:  start_mask <= wdata[OUTBITS-1:0];
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_trigger_gen.sv
// tb_red_pitaya_trigger_gen: scoreboard bench with a pulse-train
// reference model computed from delay/width/period/count rules.
`timescale 1ns/1ps
module tb_red_pitaya_trigger_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] trig_i = '0;
    logic [15:0] trig_o;
    logic        pulse_o;
    logic        busy_o;
    logic [15:0] addr = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;

    red_pitaya_trigger_gen #(.OUTBITS(16), .CTRBITS(64)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .trig_i (trig_i),
        .trig_o (trig_o),
        .pulse_o(pulse_o),
        .busy_o (busy_o),
        .addr   (addr),
        .wen    (wen),
        .ren    (ren),
        .ack    (ack),
        .rdata  (rdata),
        .wdata  (wdata)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {bit rd; logic [15:0] a; logic [31:0] d;} bus_t;
    typedef struct {int c; logic [15:0] m;} rise_t;

    bus_t  bus_q[$];
    rise_t rise_q[$];
    int    fall_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit hi;
    bit prev_hi = 1'b0;
    bus_t  be;
    rise_t re;
    int    fe;

    function automatic void chk(bit ok, string nm, longint act, longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cyc %0d", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT shows ack or an edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_hi = 1'b0;
        end else begin
            hi = (trig_o != 16'd0);
            if (ack) begin
                if (bus_q.size() == 0) begin
                    chk(0, "ack_unexpected", 1, 0);
                end else begin
                    be = bus_q.pop_front();
                    if (be.rd)
                        chk(rdata == be.d, $sformatf("rdata@%h", be.a),
                            rdata, be.d);
                end
            end
            if (hi && !prev_hi) chk(pulse_o, "pulse_on_rise", pulse_o, 1);
            if (pulse_o) begin
                if (rise_q.size() == 0) begin
                    chk(0, "pulse_unexpected", cyc, 0);
                end else begin
                    re = rise_q.pop_front();
                    chk(cyc == re.c, "rise_cyc", cyc, re.c);
                    chk(trig_o == re.m, "rise_mask", trig_o, re.m);
                end
            end
            if (!hi && prev_hi) begin
                if (fall_q.size() == 0) begin
                    chk(0, "fall_unexpected", cyc, 0);
                end else begin
                    fe = fall_q.pop_front();
                    chk(cyc == fe, "fall_cyc", cyc, fe);
                end
            end
            prev_hi = hi;
        end
    end

    task automatic op(bit r, logic [15:0] a, logic [31:0] d, logic [31:0] e);
        @(negedge clk);
        addr  = a;
        wen   = !r;
        ren   = r;
        wdata = d;
        bus_q.push_back('{r, a, e});
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d);
        op(1'b0, a, d, 32'd0);
    endtask

    task automatic rd(logic [15:0] a, logic [31:0] e);
        op(1'b1, a, 32'd0, e);
    endtask

    task automatic rd_ctr();
        @(negedge clk);
        addr = 16'h15C;
        wen  = 1'b0;
        ren  = 1'b1;
        bus_q.push_back('{1'b1, 16'h15C, 32'(cyc)});
    endtask

    task automatic idle();
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(int bound, int exp_end);
        int n;
        n = 0;
        while (busy_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) chk(0, "idle_timeout", n, bound);
        else        chk(cyc == exp_end, "end_cyc", cyc, exp_end);
    endtask

    task automatic run_burst(int d, int w, int p, int c,
                             logic [15:0] m, bit restart);
        int we, pe, ce, k, r;
        we = (w == 0) ? 1 : w;
        pe = (p <= we) ? we + 1 : p;
        ce = (c == 0) ? 1 : c;
        wr(16'h104, 0);
        wr(16'h108, 32'(m));
        wr(16'h10C, d);
        wr(16'h110, w);
        wr(16'h114, p);
        wr(16'h118, c);
        rd(16'h10C, d);
        rd(16'h110, w);
        wr(16'h100, 0);
        k = cyc + 1;
        idle();
        for (int i = 0; i < ce; i++) begin
            r = k + 2 + d + i * pe;
            rise_q.push_back('{r, m});
            fall_q.push_back(r + we);
        end
        if (restart) begin
            wait_cyc(k + 2 + d);
            wr(16'h100, 0);
            idle();
        end
        wait_cyc(k + 1);
        wait_idle(2000, k + 2 + d + (ce - 1) * pe + we);
        rd(16'h100, 0);
        rd(16'h16C, ce);
        rd(16'h164, k + 1 + d + (ce - 1) * pe);
        rd(16'h168, 0);
        idle();
    endtask

    initial begin
        int k, j, d, r100;
        #12;
        chk(trig_o == 0 && pulse_o == 0 && busy_o == 0, "rst_outs",
            {trig_o, pulse_o, busy_o}, 0);
        chk(ack == 0 && rdata == 0, "rst_bus", {ack, rdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 mon_en = 1'b1;
        rd(16'h110, 1);
        rd(16'h114, 2);
        rd(16'h118, 1);
        rd(16'h104, 0);
        rd(16'h200, 0);
        rd(16'h120, 0);
        idle();

        run_burst(0, 3, 5, 2, 16'h0001, 1'b1);
        run_burst(1, 4, 2, 3, 16'h00F0, 1'b0);
        run_burst(2, 0, 0, 3, 16'h8001, 1'b0);
        for (int t = 0; t < 6; t++)
            run_burst($urandom_range(0, 5), $urandom_range(0, 4),
                      $urandom_range(0, 7), $urandom_range(0, 3),
                      16'($urandom_range(1, 65535)), 1'b0);

        // External start: only a rising edge on a start_mask bit counts.
        d = $urandom_range(0, 3);
        wr(16'h104, 2);
        wr(16'h11C, 4);
        wr(16'h108, 16'h3000);
        wr(16'h10C, d);
        wr(16'h110, 2);
        wr(16'h114, 3);
        wr(16'h118, 2);
        wr(16'h100, 0);
        k = cyc + 1;
        idle();
        wait_cyc(k + 20);
        chk(busy_o, "ext_busy", busy_o, 1);
        rd(16'h100, 1);
        idle();
        @(negedge clk);
        trig_i = 16'h0008;
        @(negedge clk);
        trig_i = 16'h000C;
        j = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            rise_q.push_back('{j + 1 + d + i * 3, 16'h3000});
            fall_q.push_back(j + 1 + d + i * 3 + 2);
        end
        wait_cyc(j);
        wait_idle(200, j + 1 + d + 3 + 2);
        trig_i = 16'h0000;

        // Continuous train, aborted during the 100th pulse.
        wr(16'h104, 1);
        wr(16'h108, 16'h0A5A);
        wr(16'h10C, 1);
        wr(16'h110, 3);
        wr(16'h114, 4);
        wr(16'h118, 0);
        wr(16'h100, 0);
        k = cyc + 1;
        idle();
        r100 = k + 3 + 99 * 4;
        for (int i = 0; i < 100; i++) begin
            rise_q.push_back('{k + 3 + i * 4, 16'h0A5A});
            if (i < 99) fall_q.push_back(k + 3 + i * 4 + 3);
        end
        fall_q.push_back(r100 + 1);
        wait_cyc(r100 - 2);
        wr(16'h120, 0);
        idle();
        wait_idle(20, r100 + 1);
        rd(16'h100, 0);
        rd(16'h16C, 100);
        rd(16'h164, r100 - 1);
        idle();

        // Abort right behind start: no pulse may appear.
        wr(16'h104, 0);
        wr(16'h10C, 0);
        wr(16'h100, 0);
        wr(16'h120, 0);
        idle();
        repeat (5) @(negedge clk);
        chk(!busy_o, "abort_idle", busy_o, 0);
        rd(16'h100, 0);
        rd(16'h16C, 0);
        idle();

        // Asynchronous reset during a HIGH phase.
        wr(16'h104, 1);
        wr(16'h108, 16'h00FF);
        wr(16'h110, 6);
        wr(16'h114, 9);
        wr(16'h100, 0);
        k = cyc + 1;
        idle();
        rise_q.push_back('{k + 2, 16'h00FF});
        wait_cyc(k + 4);
        #2 mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk(trig_o == 0, "async_trig", trig_o, 0);
        chk(!busy_o, "async_busy", busy_o, 0);
        #1 rst = 1'b0;
        chk(rise_q.size() == 0, "rise_before_rst", rise_q.size(), 0);
        fall_q.delete();
        bus_q.delete();
        @(negedge clk);
        #1 mon_en = 1'b1;
        rd(16'h110, 1);
        rd(16'h114, 2);
        rd(16'h104, 0);
        rd_ctr();
        rd(16'h160, 0);
        idle();

        repeat (4) @(negedge clk);
        chk(rise_q.size() == 0, "rise_left", rise_q.size(), 0);
        chk(fall_q.size() == 0, "fall_left", fall_q.size(), 0);
        chk(bus_q.size() == 0, "bus_left", bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/red_pitaya_trigger_gen.md
Name: red_pitaya_trigger_gen

Overview:
Programmable trigger pulse-train generator, the transmit side of the trigger network. The trigger block consumes triggers on its 16-bit trigger bus; this block produces them. It emits a delayed, width- and period-controlled burst (or continuous train) of pulses on a masked 16-bit trigger output, starting either on a software start or on an incoming trigger edge. It is a sys-bus register responder like the other DSP modules and timestamps every emitted pulse against a free-running 64-bit counter.

Parameters:
OUTBITS, 16, width of trig_o and trig_i buses
CTRBITS, 64, width of free-running counter and timestamp

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
trig_i  in  16  incoming trigger lines (external start source)
trig_o  out  16  generated trigger lines, registered
pulse_o  out  1  single-cycle strobe on each pulse rising edge
busy_o  out  1  high whenever FSM not in IDLE
addr  in  16  bus address
wen  in  1  bus write strobe
ren  in  1  bus read strobe
ack  out  1  bus acknowledge, registered
rdata  out  32  bus read data, registered
wdata  in  32  bus write data

Behaviour:
- Reset (async, rst_i=1): trig_o=0, pulse_o=0, busy_o=0, ack=0, rdata=0, FSM=IDLE, all counters 0; regs: control=0, out_mask=0, delay=0, width=1, period=2, count=1, start_mask=0.
- Register map (R/W unless noted): 0x100 W: start strobe, R: {29'b0, state[2:0]}; 0x104 control {ext_start bit1, continuous bit0}; 0x108 out_mask[15:0]; 0x10C delay[31:0]; 0x110 width[31:0]; 0x114 period[31:0]; 0x118 count[31:0]; 0x11C start_mask[15:0]; 0x120 W: abort strobe, R: 0; 0x15C/0x160 ctr lo/hi (RO); 0x164/0x168 timestamp of last pulse lo/hi (RO); 0x16C pulses_emitted (RO). Other addresses read 0.
- Bus: ack <= wen|ren one cycle after the strobe, for every address. rdata valid in same cycle as ack. Start/abort are one-cycle internal strobes registered after the write edge.
- Shadowing: delay, width, period, count, continuous are latched on leaving IDLE; mid-run writes take effect on next start. out_mask is live and applies on the next edge.
- Sanitising at latch: width=0 -> 1; period<=width -> width+1; count=0 with continuous=0 -> 1.
- FSM states: IDLE(0), WAIT_EXT(1), DELAY(2), HIGH(3), LOW(4).
- IDLE: start strobe -> WAIT_EXT if ext_start else DELAY; load delay counter=delay, clear pulses_emitted.
- WAIT_EXT: rising edge of any (trig_i & start_mask) bit (compared against previous-cycle register) -> DELAY.
- DELAY: counter==0 -> HIGH, else decrement. Write at edge k with delay=D, ext_start=0 -> trig_o first high after edge k+2+D.
- HIGH: trig_o=out_mask, lasts exactly width cycles; pulse_o high in first HIGH cycle only; timestamp<=ctr and pulses_emitted++ on entry.
- LOW: trig_o=0 for period-width cycles. Then HIGH again if continuous or pulses_emitted<count, else IDLE.
- Last pulse in non-continuous mode: HIGH -> IDLE directly (no trailing LOW).
- Abort strobe: any state -> IDLE next edge, trig_o=0 next edge. Abort and start in same cycle: abort wins.
- Start while not IDLE: ignored.
- ctr: free-running +1 every cycle, wraps at 2^64; timestamps take raw value.
- pulses_emitted saturates at 2^32-1 in continuous mode.
- Reset mid-pulse: trig_o drops immediately (async).

Test Plan:
- delay=0,width=3,period=5,count=2,mask=0x0001; start at edge k -> trig_o[0] high edges k+2..k+4, low k+5..k+6, high k+7..k+9, then IDLE; pulses_emitted=2; busy_o low after k+10.
- width=4,period=2 (period<=width) -> effective period 5; width=0 -> 1-cycle pulses; verify via pulse_o spacing.
- ext_start=1,start_mask=0x0004; start, hold trig_i=0 for 20 cycles -> no output; raise trig_i[2] -> first pulse after 2+delay cycles; trig_i[3] edge ignored.
- continuous=1, run 100 pulses, write abort mid-HIGH -> trig_o=0 next edge, state reads 0, timestamp equals ctr at 100th rising edge.
- Start and abort written in consecutive cycles and same-cycle (via forced strobes) -> abort wins, no pulse; start during HIGH ignored, no restart.
- Assert rst_i asynchronously mid-HIGH -> trig_o=0 without clock edge, width reads 1, period 2, ctr restarts at 0.
